// File: rtl/biquad_coef_ctrl.sv
// Coefficient shadow/active bank controller and sample-strobe divider for one biquad filter.
// Latency: shadow write 1 cycle; swap on the sample-boundary edge; swap_done/wr_err 1 cycle after their cause.
// No backpressure: writes or commits that cannot be accepted are dropped and flagged on wr_err.
module biquad_coef_ctrl #(
    parameter int COEF_WIDTH     = 30,
    parameter int COEF_INT_WIDTH = 4,
    parameter int DIV            = 128,
    parameter int FLUSH_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [COEF_WIDTH-1:0] wr_data,
    input  logic                  commit,
    input  logic                  commit_clr,
    output logic [COEF_WIDTH-1:0] b0,
    output logic [COEF_WIDTH-1:0] b1,
    output logic [COEF_WIDTH-1:0] b2,
    output logic [COEF_WIDTH-1:0] a1,
    output logic [COEF_WIDTH-1:0] a2,
    output logic                  sample_valid,
    output logic                  filter_rst,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  wr_err
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

    // 1.0 in the coefficient fixed-point format: pass-through b0.
    localparam logic [COEF_WIDTH-1:0] COEF_ONE =
        {{(COEF_INT_WIDTH-1){1'b0}}, 1'b1, {(COEF_WIDTH-COEF_INT_WIDTH){1'b0}}};
    localparam logic [COEF_WIDTH-1:0] COEF_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            clr_q;
    logic            clr_nxt;
    logic [FL_W-1:0] flush_cnt_q;
    logic [FL_W-1:0] flush_cnt_nxt;
    logic [CNT_W-1:0] div_cnt_q;

    logic wrap;
    logic swap;
    logic swap_q;
    logic wr_ok;
    logic wr_bad;
    logic commit_bad;
    logic sv_nxt;
    logic frst_nxt;

    logic [COEF_WIDTH-1:0] sh_b0;
    logic [COEF_WIDTH-1:0] sh_b1;
    logic [COEF_WIDTH-1:0] sh_b2;
    logic [COEF_WIDTH-1:0] sh_a1;
    logic [COEF_WIDTH-1:0] sh_a2;

    // Last cycle of a sample period; only meaningful while the divider runs.
    assign wrap = run && (div_cnt_q == CNT_LAST);

    // Shadow writes are only taken while no swap is pending or flushing.
    assign wr_ok  = wr_en && (wr_addr <= 3'd4) && (state_q == ST_IDLE);
    assign wr_bad = wr_en && !wr_ok;

    // Sample-rate divider: free-runs 0..DIV-1 while run is high, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else if (!run || wrap) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // FSM state, latched flush request and flush-length counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            clr_q       <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_nxt;
            clr_q       <= clr_nxt;
            flush_cnt_q <= flush_cnt_nxt;
        end
    end

    // Next state, swap decision, strobe gating and filter reset request.
    always_comb begin
        state_nxt     = state_q;
        clr_nxt       = clr_q;
        flush_cnt_nxt = flush_cnt_q;
        swap          = 1'b0;
        sv_nxt        = 1'b0;
        frst_nxt      = 1'b0;
        commit_bad    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The filter is still held in reset on the first cycle after reset release.
                sv_nxt = wrap && !filter_rst;
                if (commit) begin
                    state_nxt = ST_ARMED;
                    clr_nxt   = commit_clr;
                end
            end
            ST_ARMED: begin
                commit_bad = commit;
                // Swap on the sample boundary, or immediately when no samples are flowing.
                if (wrap || !run) begin
                    swap = 1'b1;
                    if (clr_q) begin
                        // The boundary strobe is eaten: the filter is about to be reset.
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = '0;
                        frst_nxt      = 1'b1;
                    end else begin
                        // The boundary strobe is the first sample with the new set.
                        state_nxt = ST_IDLE;
                        sv_nxt    = wrap;
                    end
                end
            end
            ST_FLUSH: begin
                commit_bad = commit;
                // filter_rst was raised at the swap edge; hold it FLUSH_CYCLES cycles in total.
                if (flush_cnt_q == FL_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt_q + 1'b1;
                    frst_nxt      = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs; swap_done trails the bank change by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid <= 1'b0;
            filter_rst   <= 1'b1;
            busy         <= 1'b0;
            swap_q       <= 1'b0;
            swap_done    <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            sample_valid <= sv_nxt;
            filter_rst   <= frst_nxt;
            busy         <= (state_nxt != ST_IDLE);
            swap_q       <= swap;
            swap_done    <= swap_q;
            wr_err       <= wr_bad || commit_bad;
        end
    end

    // Shadow bank: host-visible staging area, reset to a pass-through set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_b0 <= COEF_ONE;
            sh_b1 <= COEF_ZERO;
            sh_b2 <= COEF_ZERO;
            sh_a1 <= COEF_ZERO;
            sh_a2 <= COEF_ZERO;
        end else if (wr_ok) begin
            case (wr_addr)
                3'd0:    sh_b0 <= wr_data;
                3'd1:    sh_b1 <= wr_data;
                3'd2:    sh_b2 <= wr_data;
                3'd3:    sh_a1 <= wr_data;
                3'd4:    sh_a2 <= wr_data;
                default: sh_b0 <= sh_b0;
            endcase
        end
    end

    // Active bank: all five coefficients move together, only on a swap edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b0 <= COEF_ONE;
            b1 <= COEF_ZERO;
            b2 <= COEF_ZERO;
            a1 <= COEF_ZERO;
            a2 <= COEF_ZERO;
        end else if (swap) begin
            b0 <= sh_b0;
            b1 <= sh_b1;
            b2 <= sh_b2;
            a1 <= sh_a1;
            a2 <= sh_a2;
        end
    end

endmodule
